frame_scheduler: RTL and testbench

Per-frame controller that sequences the render datapath once per display frame. It waits for a frame tick, optionally clears the screen through the screen writer, then walks an object table. For each object it runs the MVP pipe followed by the triangle-draw pipe. It sits above the existing MVP/draw-pipe pair and replaces single-shot start buttons with continuous, tick-paced rendering of up to MAX_OBJECTS meshes.

---
 rtl/frame_sched_pkg.sv | 21 ++
 rtl/frame_scheduler.sv | 150 +++++++++++++++
 tb/tb_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the per-frame render scheduler.
package frame_sched_pkg;

  localparam int unsigned FRAME_COUNT_W     = 16;
  localparam int unsigned OVERRUN_W         = 8;
  localparam int unsigned DEFAULT_BG_COLOUR = 0;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_TICK,
    CLEAR,
    CLEAR_WAIT,
    MVP,
    MVP_WAIT,
    DRAW,
    DRAW_WAIT,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/frame_scheduler.sv
// Tick-paced frame controller: optional screen clear, then MVP + draw per object.
// Optional clear stage enabled by defining FRAME_SCHED_CLEAR_EN.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned COLOUR_WIDTH = 3,
  parameter int unsigned MAX_OBJECTS  = 4,
  parameter int unsigned BG_COLOUR    = DEFAULT_BG_COLOUR,
  localparam int unsigned OW          = $clog2(MAX_OBJECTS) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     frame_tick,
  input  logic [OW-1:0]            obj_count,
  output logic [OW-2:0]            obj_idx,
  input  logic [WIDTH-1:0]         obj_vtx_count,
  input  logic [WIDTH-1:0]         obj_tri_count,
  output logic                     mvp_start,
  output logic                     mvp_update_mvp,
  output logic [WIDTH-1:0]         mvp_count,
  input  logic                     mvp_done,
  output logic                     tri_start,
  output logic [WIDTH-1:0]         tri_count,
  input  logic                     tri_done,
  output logic                     clr_start,
  output logic [COLOUR_WIDTH-1:0]  new_screen_colour,
  input  logic                     clr_done,
  output logic                     screen_sel,
  output logic                     busy,
  output logic                     frame_done,
  output logic [FRAME_COUNT_W-1:0] frame_count,
  output logic [OVERRUN_W-1:0]     overrun_count
);

  state_t           state, state_d;
  logic [OW-1:0]    idx, idx_d;
  logic [OW-1:0]    count_cl;
  logic             mvp_start_d, mvp_update_d, tri_start_d, clr_start_d;
  logic             screen_sel_d, busy_d, frame_done_d;
  logic [WIDTH-1:0] mvp_count_d, tri_count_d;

`ifndef FRAME_SCHED_CLEAR_EN
  logic unused_clr_done;
  assign unused_clr_done = clr_done;
`endif

  assign count_cl = (obj_count > OW'(MAX_OBJECTS)) ? OW'(MAX_OBJECTS) : obj_count;
  assign obj_idx  = idx[OW-2:0];

  // Next state plus the values every output register takes on the next edge.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    mvp_start_d  = 1'b0;
    mvp_update_d = 1'b0;
    tri_start_d  = 1'b0;
    clr_start_d  = 1'b0;
    screen_sel_d = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    mvp_count_d  = mvp_count;
    tri_count_d  = tri_count;

    case (state)
      IDLE:      if (enable) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (frame_tick) begin
`ifdef FRAME_SCHED_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = (count_cl == '0) ? DONE : MVP;
`endif
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
`ifdef FRAME_SCHED_CLEAR_EN
      CLEAR:      state_d = CLEAR_WAIT;
      CLEAR_WAIT: if (clr_done) state_d = (count_cl == '0) ? DONE : MVP;
`endif
      MVP:        state_d = MVP_WAIT;
      MVP_WAIT:   if (mvp_done) state_d = DRAW;
      DRAW:       state_d = (tri_count == '0) ? NEXT : DRAW_WAIT;
      DRAW_WAIT:  if (tri_done) state_d = NEXT;
      NEXT:       state_d = (idx >= count_cl) ? DONE : MVP;
      DONE:       state_d = enable ? WAIT_TICK : IDLE;
      default:    state_d = IDLE;
    endcase

    // Index advances on entry to NEXT so the table already shows the next object there.
    if (state_d == IDLE || state_d == WAIT_TICK || state_d == CLEAR) idx_d = '0;
    if (state_d == NEXT) idx_d = idx + OW'(1);

    if (state_d == MVP) begin
      mvp_start_d  = 1'b1;
      mvp_update_d = (idx == '0);
      mvp_count_d  = obj_vtx_count;
    end
    if (state_d == DRAW) begin
      tri_start_d = (obj_tri_count != '0);
      tri_count_d = obj_tri_count;
    end
`ifdef FRAME_SCHED_CLEAR_EN
    clr_start_d  = (state_d == CLEAR);
    screen_sel_d = (state_d == CLEAR) || (state_d == CLEAR_WAIT);
`endif
    busy_d       = (state_d != IDLE) && (state_d != WAIT_TICK);
    frame_done_d = (state_d == DONE);
  end

  // State, index and all output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      mvp_start         <= 1'b0;
      mvp_update_mvp    <= 1'b0;
      mvp_count         <= '0;
      tri_start         <= 1'b0;
      tri_count         <= '0;
      clr_start         <= 1'b0;
      new_screen_colour <= '0;
      screen_sel        <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      frame_count       <= '0;
      overrun_count     <= '0;
    end else begin
      state             <= state_d;
      idx               <= idx_d;
      mvp_start         <= mvp_start_d;
      mvp_update_mvp    <= mvp_update_d;
      mvp_count         <= mvp_count_d;
      tri_start         <= tri_start_d;
      tri_count         <= tri_count_d;
      clr_start         <= clr_start_d;
      new_screen_colour <= COLOUR_WIDTH'(BG_COLOUR);
      screen_sel        <= screen_sel_d;
      busy              <= busy_d;
      frame_done        <= frame_done_d;
      if (frame_done_d) frame_count <= frame_count + FRAME_COUNT_W'(1);
      // A tick arriving mid-frame is dropped and only counted.
      if (frame_tick && busy && overrun_count != '1)
        overrun_count <= overrun_count + OVERRUN_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: directed frames, pipe responders, event monitor.
`timescale 1ns/1ps
module tb_frame_scheduler;
  import frame_sched_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = 3;
  localparam int unsigned OW    = 3;
  localparam int EV_CLR = 0, EV_MVP = 1, EV_TRI = 2, EV_FD = 3;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b0;
  logic                     frame_tick = 1'b0;
  logic [OW-1:0]            obj_count = '0;
  logic [OW-2:0]            obj_idx;
  logic [WIDTH-1:0]         obj_vtx_count, obj_tri_count;
  logic                     mvp_start, mvp_update_mvp, mvp_done = 1'b0;
  logic [WIDTH-1:0]         mvp_count, tri_count;
  logic                     tri_start, tri_done = 1'b0;
  logic                     clr_start, clr_done = 1'b0, screen_sel;
  logic [CW-1:0]            new_screen_colour;
  logic                     busy, frame_done;
  logic [FRAME_COUNT_W-1:0] frame_count;
  logic [OVERRUN_W-1:0]     overrun_count;

  logic [WIDTH-1:0] vtx  [4];
  logic [WIDTH-1:0] tris [4];
  assign obj_vtx_count = vtx[obj_idx];
  assign obj_tri_count = tris[obj_idx];

  frame_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .obj_count(obj_count), .obj_idx(obj_idx),
    .obj_vtx_count(obj_vtx_count), .obj_tri_count(obj_tri_count),
    .mvp_start(mvp_start), .mvp_update_mvp(mvp_update_mvp), .mvp_count(mvp_count),
    .mvp_done(mvp_done), .tri_start(tri_start), .tri_count(tri_count), .tri_done(tri_done),
    .clr_start(clr_start), .new_screen_colour(new_screen_colour), .clr_done(clr_done),
    .screen_sel(screen_sel), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  typedef struct { int kind; int val; int upd; } ev_t;
  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  int mvp_lat = 5, tri_lat = 5, clr_lat = 3;
  int mvp_t = 0, tri_t = 0, clr_t = 0;

  task automatic push(input int kind, input int val, input int upd);
    ev_t e;
    e.kind = kind; e.val = val; e.upd = upd;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input int val, input int upd);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d flag=%0d, required no event", kind, val, upd);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.upd != upd) begin
        n_err++;
        $display("FAIL event_order: got kind=%0d val=%0d flag=%0d, required kind=%0d val=%0d flag=%0d",
                 kind, val, upd, e.kind, e.val, e.upd);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Pipe models: each done pulses for one cycle a fixed latency after its start.
  initial forever begin
    @(negedge clock);
    mvp_done = 1'b0; tri_done = 1'b0; clr_done = 1'b0;
    if (mvp_t > 0) begin mvp_t--; if (mvp_t == 0) mvp_done = 1'b1; end
    if (tri_t > 0) begin tri_t--; if (tri_t == 0) tri_done = 1'b1; end
    if (clr_t > 0) begin clr_t--; if (clr_t == 0) clr_done = 1'b1; end
    if (mvp_start) mvp_t = mvp_lat;
    if (tri_start) tri_t = tri_lat;
    if (clr_start) clr_t = clr_lat;
  end

  // Monitor: every observed pulse is matched against the expected event queue.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (clr_start)  take(EV_CLR, 0, int'(screen_sel));
      if (mvp_start)  take(EV_MVP, int'(mvp_count), int'(mvp_update_mvp));
      if (tri_start)  take(EV_TRI, int'(tri_count), 0);
      if (frame_done) take(EV_FD, int'(frame_count), int'(busy));
    end
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int budget);
    int k = 0;
    while (!frame_done && k < budget) begin @(negedge clock); k++; end
    n_cmp++;
    if (!frame_done) begin
      n_err++;
      $display("FAIL %s: got no frame_done within %0d cycles, required frame_done", name, budget);
    end
  endtask

  task automatic wait_tri(input string name, input int budget);
    int k = 0;
    while (!tri_start && k < budget) begin @(negedge clock); k++; end
    check(name, 32'(tri_start), 32'd1);
  endtask

  task automatic wait_mvp(input string name, input int budget);
    int k = 0;
    while (!mvp_start && k < budget) begin @(negedge clock); k++; end
    check(name, 32'(mvp_start), 32'd1);
  endtask

  task automatic push_clr();
`ifdef FRAME_SCHED_CLEAR_EN
    push(EV_CLR, 0, 1);
`endif
  endtask

  function automatic logic all_zero();
    return ~|{mvp_start, mvp_update_mvp, mvp_count, tri_start, tri_count, clr_start,
              new_screen_colour, screen_sel, busy, frame_done, frame_count, overrun_count, obj_idx};
  endfunction

  initial begin
    vtx[0] = 10; vtx[1] = 11; vtx[2] = 12; vtx[3] = 13;
    tris[0] = 2; tris[1] = 3; tris[2] = 0; tris[3] = 4;
    repeat (3) @(negedge clock);
    check("reset_outputs_zero", 32'(all_zero()), 32'd1);

    // Two objects, one tick.
    reset = 1'b0; enable = 1'b1; obj_count = 3'd2;
    repeat (3) @(negedge clock);
    check("wait_tick_not_busy", 32'(busy), 32'd0);
    push_clr();
    push(EV_MVP, 10, 1); push(EV_TRI, 2, 0);
    push(EV_MVP, 11, 0); push(EV_TRI, 3, 0);
    push(EV_FD, 1, 1);
    tick();
`ifdef FRAME_SCHED_CLEAR_EN
    check("tick_to_clr_start", 32'(clr_start), 32'd1);
`else
    check("tick_to_mvp_start", 32'(mvp_start), 32'd1);
`endif
    check("busy_after_tick", 32'(busy), 32'd1);
    wait_frame("frame1_done", 200);
    @(negedge clock);
    check("frame_count_1", 32'(frame_count), 32'd1);
    check("back_to_wait_tick", 32'(busy), 32'd0);
    check("queue_drained_1", 32'(exp_q.size()), 32'd0);

    // Empty object list.
    obj_count = 3'd0;
    push_clr();
    push(EV_FD, 2, 1);
    tick();
    wait_frame("empty_frame_done", 50);
    @(negedge clock);
    check("frame_count_2", 32'(frame_count), 32'd2);
    check("queue_drained_2", 32'(exp_q.size()), 32'd0);

    // Count above MAX_OBJECTS clamps to 4; object 2 has no triangles.
    obj_count = 3'd7;
    push_clr();
    push(EV_MVP, 10, 1); push(EV_TRI, 2, 0);
    push(EV_MVP, 11, 0); push(EV_TRI, 3, 0);
    push(EV_MVP, 12, 0);
    push(EV_MVP, 13, 0); push(EV_TRI, 4, 0);
    push(EV_FD, 3, 1);
    tick();
    wait_frame("clamped_frame_done", 300);
    @(negedge clock);
    check("queue_drained_3", 32'(exp_q.size()), 32'd0);

    // Three ticks during one long frame.
    obj_count = 3'd1; mvp_lat = 40;
    push_clr();
    push(EV_MVP, 10, 1); push(EV_TRI, 2, 0); push(EV_FD, 4, 1);
    tick();
    repeat (3) begin repeat (4) @(negedge clock); tick(); end
    wait_frame("overrun_frame_done", 300);
    @(negedge clock);
    check("overrun_3", 32'(overrun_count), 32'd3);

    // 300 more missed ticks saturate the counter.
    mvp_lat = 700;
    push_clr();
    push(EV_MVP, 10, 1); push(EV_TRI, 2, 0); push(EV_FD, 5, 1);
    tick();
    repeat (300) begin @(negedge clock); tick(); end
    wait_frame("saturate_frame_done", 1000);
    @(negedge clock);
    check("overrun_saturated", 32'(overrun_count), 32'd255);
    check("queue_drained_4", 32'(exp_q.size()), 32'd0);

    // Enable dropped in DRAW_WAIT: frame completes, then idle.
    mvp_lat = 5; obj_count = 3'd2;
    push_clr();
    push(EV_MVP, 10, 1); push(EV_TRI, 2, 0);
    push(EV_MVP, 11, 0); push(EV_TRI, 3, 0);
    push(EV_FD, 6, 1);
    tick();
    wait_tri("first_tri_start", 100);
    @(negedge clock);
    enable = 1'b0;
    wait_frame("disable_frame_done", 200);
    @(negedge clock);
    check("idle_not_busy", 32'(busy), 32'd0);
    tick();
    repeat (5) @(negedge clock);
    check("idle_ignores_tick", 32'(busy), 32'd0);
    check("idle_no_overrun", 32'(overrun_count), 32'd255);
    check("frame_count_6", 32'(frame_count), 32'd6);
    check("queue_drained_5", 32'(exp_q.size()), 32'd0);

    // Reset in MVP_WAIT abandons the frame; the late mvp_done is ignored.
    enable = 1'b1; mvp_lat = 20;
    push_clr();
    push(EV_MVP, 10, 1);
    repeat (2) @(negedge clock);
    tick();
    wait_mvp("mvp_start_before_reset", 50);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid_frame_zero", 32'(all_zero()), 32'd1);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("after_reset_not_busy", 32'(busy), 32'd0);
    check("after_reset_frames", 32'(frame_count), 32'd0);
    check("queue_drained_6", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
